sprdma_channel: RTL and testbench
=================================

Name: sprdma_channel

Overview:
- Sprite DMA sequencer for one sprite channel. It is the initiator/writer end of the sprite register bus.
- Fetches control words (POS/CTL) and bitplane words (DATA/DATB) from chip memory via a word pointer, using a req/ack handshake.
- Issues single-cycle register writes (aen/address/data_out) to the sprite shifter.
- Sequencing is driven by two per-line DMA slots, the vertical beam position and a frame-start pulse.

Parameters:
- AW, 19, chip memory word-address width.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- vbl_end  in  1  one-cycle pulse at start of frame (end of vertical blank)
- vpos  in  9  current beam line
- slot  in  1  one-cycle pulse: channel owns a DMA slot
- slot_sel  in  1  slot index qualifying slot (0 = first slot of line, 1 = second)
- ptr_we  in  1  pointer load strobe
- ptr_data  in  AW  new pointer value
- mem_req  out  1  memory read request
- mem_addr  out  AW  word address, stable while mem_req=1
- mem_ack  in  1  read complete; mem_rdata valid this cycle only
- mem_rdata  in  16  read data
- aen  out  1  register write strobe, one cycle per write
- address  out  2  register select: 00 POS, 01 CTL, 10 DATA, 11 DATB
- data_out  out  16  register write data
- busy  out  1  1 while mem_req outstanding or register write pending

Behaviour:
- Reset: state IDLE, ptr=0, vstart=0, vstop=0, mem_req=0, mem_addr=0, aen=0, address=00, data_out=0, busy=0.
- States: IDLE, CTL_POS, CTL_CTL, WAIT_START, ACTIVE_A, ACTIVE_B, DONE.
- vbl_end: next state CTL_POS from any state, same cycle it is seen.
  - If mem_req is outstanding, the handshake completes but the returned data is discarded.
  - No aen is issued for that discarded fetch.
- Fetch:
  - Starts on a slot pulse with matching slot_sel in an eligible state.
  - mem_req=1 and mem_addr=ptr on the cycle after the slot pulse; both held until mem_ack.
  - On mem_ack: mem_req=0 and ptr=ptr+1, modulo 2^AW (wraps).
- Ignored slot pulses: a slot pulse while busy=1, or with a non-matching slot_sel, causes no fetch.
- ptr_we: ptr=ptr_data next cycle. It overrides the increment of a coincident ack. An address already on mem_addr is unchanged.
- Register writes: aen=1 for exactly one cycle, starting the cycle after the relevant ack; address/data_out valid with it and held after. Otherwise aen=0.
- CTL_POS (slot_sel=0): fetch POS word.
  - Write POS=rdata.
  - vstart[7:0]=rdata[15:8].
  - Go to CTL_CTL.
- CTL_CTL (slot_sel=1): fetch CTL word.
  - Write CTL=rdata.
  - vstop[7:0]=rdata[15:8], vstart[8]=rdata[2], vstop[8]=rdata[1].
  - If POS word and CTL word are both 0: go to DONE. Otherwise go to WAIT_START.
- WAIT_START, on each slot_sel=0 pulse:
  - If vpos==vstop: go to CTL_POS and fetch POS this slot. This takes priority, and covers vstart==vstop, which displays zero lines.
  - Else if vpos==vstart: go to ACTIVE_A and fetch the DATA word this slot.
  - Otherwise no fetch.
- ACTIVE_A:
  - slot_sel=0 pulse with vpos==vstop: go to CTL_POS and fetch POS this slot.
  - Otherwise, on slot_sel=0: fetch DATA word into holding register, no write yet, go to ACTIVE_B.
- ACTIVE_B (slot_sel=1): fetch DATB word.
  - ack+1: write DATB=rdata.
  - ack+2: write DATA=held word. DATA is written last so the shifter arms after both words are loaded.
  - Go to ACTIVE_A.
- DONE: ignores slots until vbl_end.
- IDLE: left only by vbl_end.
- Reset mid-handshake: mem_req drops next cycle; memory side must tolerate abandoned requests.

Test Plan:
- Reset, ptr_we ptr_data=0x00100, vbl_end; slot0 ack rdata=0x3040, slot1 ack rdata=0x3200.
  - Expect aen POS=0x3040, then CTL=0x3200.
  - vstart=0x030, vstop=0x032, ptr=0x00102, state WAIT_START.
- Continue with vpos=0x030:
  - slot0 ack rdata=0xAAAA, slot1 ack rdata=0x5555.
  - Expect DATB=0x5555 at ack+1, DATA=0xAAAA at ack+2, ptr=0x00104.
  - Repeat at vpos=0x031. At vpos=0x032 slot0 fetches from 0x00106 and writes POS.
- Control pair 0x0000/0x0000: state DONE; slot pulses for 3 lines produce no mem_req. vbl_end restarts at CTL_POS with the current ptr.
- vstart==vstop: POS=0x5000, CTL=0x5000 at vpos=0x050. Slot0 re-fetches POS; no DATA/DATB writes issued.
- Backpressure: mem_ack delayed 5 cycles.
  - mem_req/mem_addr stable throughout.
  - Slot pulse during wait ignored.
  - ptr_we=0x7FFFF then ack: ptr=0x7FFFF, not incremented. Next fetch at 0x7FFFF; ptr wraps to 0x00000.
- vbl_end while mem_req pending in ACTIVE_B: ack consumed, no DATB/DATA writes; next slot0 fetch is POS.

Source files
------------

// File: rtl/sprdma_channel.sv
// Sprite DMA sequencer for one sprite channel: fetches control and bitplane words from chip
// memory on the channel's DMA slots and writes them into the sprite shifter registers.
module sprdma_channel #(
  parameter int unsigned AW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vbl_end,
  input  logic [8:0]    vpos,
  input  logic          slot,
  input  logic          slot_sel,
  input  logic          ptr_we,
  input  logic [AW-1:0] ptr_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  output logic          aen,
  output logic [1:0]    address,
  output logic [15:0]   data_out,
  output logic          busy
);

  typedef enum logic [2:0] {
    StIdle,
    StCtlPos,
    StCtlCtl,
    StWaitStart,
    StActiveA,
    StActiveB,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    RegPos  = 2'b00,
    RegCtl  = 2'b01,
    RegData = 2'b10,
    RegDatb = 2'b11
  } reg_e;

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [8:0]    vstart_q;
  logic [8:0]    vstop_q;
  logic          req_q;
  logic [AW-1:0] addr_q;
  logic          aen_q;
  logic [1:0]    sel_q;
  logic [15:0]   wdata_q;
  logic [15:0]   hold_q;
  logic          data_pend_q;
  logic          discard_q;
  reg_e          fkind_q;
  logic          pos_zero_q;

  logic          busy_w;
  logic          start;
  reg_e          start_kind;
  state_e        start_state;

  assign busy_w = req_q | aen_q | data_pend_q;

  // Decide whether this slot pulse launches a fetch, what it fetches and where the FSM goes.
  always_comb begin
    start       = 1'b0;
    start_kind  = RegPos;
    start_state = state_q;
    if (slot && !busy_w && !vbl_end) begin
      case (state_q)
        StCtlPos: begin
          if (!slot_sel) begin
            start      = 1'b1;
            start_kind = RegPos;
          end
        end
        StCtlCtl: begin
          if (slot_sel) begin
            start      = 1'b1;
            start_kind = RegCtl;
          end
        end
        StWaitStart: begin
          if (!slot_sel) begin
            // The stop line wins so an equal start/stop pair displays nothing.
            if (vpos == vstop_q) begin
              start       = 1'b1;
              start_kind  = RegPos;
              start_state = StCtlPos;
            end else if (vpos == vstart_q) begin
              start       = 1'b1;
              start_kind  = RegData;
              start_state = StActiveA;
            end
          end
        end
        StActiveA: begin
          if (!slot_sel) begin
            start = 1'b1;
            if (vpos == vstop_q) begin
              start_kind  = RegPos;
              start_state = StCtlPos;
            end else begin
              start_kind = RegData;
            end
          end
        end
        StActiveB: begin
          if (slot_sel) begin
            start      = 1'b1;
            start_kind = RegDatb;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      vstart_q    <= '0;
      vstop_q     <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      aen_q       <= 1'b0;
      sel_q       <= 2'b00;
      wdata_q     <= '0;
      hold_q      <= '0;
      data_pend_q <= 1'b0;
      discard_q   <= 1'b0;
      fkind_q     <= RegPos;
      pos_zero_q  <= 1'b0;
    end else begin
      aen_q <= 1'b0;

      // Second write of a bitplane pair: DATA goes last so the shifter arms on a full pair.
      if (data_pend_q) begin
        aen_q       <= 1'b1;
        sel_q       <= RegData;
        wdata_q     <= hold_q;
        data_pend_q <= 1'b0;
      end

      if (req_q && mem_ack) begin
        req_q     <= 1'b0;
        ptr_q     <= ptr_q + 1'b1;
        discard_q <= 1'b0;
        if (!discard_q && !vbl_end) begin
          case (fkind_q)
            RegPos: begin
              aen_q         <= 1'b1;
              sel_q         <= RegPos;
              wdata_q       <= mem_rdata;
              vstart_q[7:0] <= mem_rdata[15:8];
              pos_zero_q    <= (mem_rdata == 16'h0000);
              state_q       <= StCtlCtl;
            end
            RegCtl: begin
              aen_q        <= 1'b1;
              sel_q        <= RegCtl;
              wdata_q      <= mem_rdata;
              vstop_q[7:0] <= mem_rdata[15:8];
              vstart_q[8]  <= mem_rdata[2];
              vstop_q[8]   <= mem_rdata[1];
              state_q      <= (pos_zero_q && mem_rdata == 16'h0000) ? StDone : StWaitStart;
            end
            RegData: begin
              hold_q  <= mem_rdata;
              state_q <= StActiveB;
            end
            default: begin
              aen_q       <= 1'b1;
              sel_q       <= RegDatb;
              wdata_q     <= mem_rdata;
              data_pend_q <= 1'b1;
              state_q     <= StActiveA;
            end
          endcase
        end
      end

      if (ptr_we) begin
        ptr_q <= ptr_data;
      end

      if (vbl_end) begin
        state_q     <= StCtlPos;
        data_pend_q <= 1'b0;
        if (req_q && !mem_ack) begin
          discard_q <= 1'b1;
        end
      end else if (start) begin
        req_q   <= 1'b1;
        addr_q  <= ptr_q;
        fkind_q <= start_kind;
        state_q <= start_state;
      end
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign aen      = aen_q;
  assign address  = sel_q;
  assign data_out = wdata_q;
  assign busy     = busy_w;

endmodule

// File: tb/tb_sprdma_channel.sv
// Scoreboard bench for sprdma_channel: expected register writes are queued as fetches are
// serviced and popped as aen strobes appear.
module tb_sprdma_channel;

  localparam int unsigned AW = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vbl_end = 1'b0;
  logic [8:0]    vpos = '0;
  logic          slot = 1'b0;
  logic          slot_sel = 1'b0;
  logic          ptr_we = 1'b0;
  logic [AW-1:0] ptr_data = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_rdata = '0;
  logic          aen;
  logic [1:0]    address;
  logic [15:0]   data_out;
  logic          busy;

  int total = 0;
  int bad = 0;
  logic [17:0] sb_q[$];

  sprdma_channel #(.AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .vbl_end  (vbl_end),
    .vpos     (vpos),
    .slot     (slot),
    .slot_sel (slot_sel),
    .ptr_we   (ptr_we),
    .ptr_data (ptr_data),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .aen      (aen),
    .address  (address),
    .data_out (data_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [15:0] d);
    sb_q.push_back({a, d});
  endtask

  // Register-write monitor
  always @(negedge clk) begin
    if (!reset && aen) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_aen", {14'h0, address, data_out}, 32'hFFFF_FFFF);
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        check_eq("wr_addr", {30'h0, address}, {30'h0, e[17:16]});
        check_eq("wr_data", {16'h0, data_out}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic do_slot(input logic sel);
    slot = 1'b1;
    slot_sel = sel;
    tick();
    slot = 1'b0;
  endtask

  task automatic no_fetch(input logic sel);
    do_slot(sel);
    repeat (3) begin
      check_eq("no_req", {31'h0, mem_req}, 32'h0);
      tick();
    end
  endtask

  // mid: 0 none, 1 extra slot pulse during the wait, 2 vbl_end during the wait
  task automatic fetch(input logic sel, input logic [AW-1:0] exp_addr, input logic [15:0] rd,
                       input int delay, input int mid, input logic ld,
                       input logic [AW-1:0] ld_val);
    int n;
    do_slot(sel);
    n = 0;
    while (!mem_req && n < 8) begin
      tick();
      n++;
    end
    check_eq("req_seen", {31'h0, mem_req}, 32'h1);
    if (!mem_req) return;
    check_eq("fetch_addr", {13'h0, mem_addr}, {13'h0, exp_addr});
    for (int i = 0; i < delay; i++) begin
      if (i == 1 && mid == 1) begin
        slot = 1'b1;
        slot_sel = 1'b0;
      end
      if (i == 1 && mid == 2) vbl_end = 1'b1;
      tick();
      slot = 1'b0;
      vbl_end = 1'b0;
      check_eq("req_hold", {31'h0, mem_req}, 32'h1);
      check_eq("addr_hold", {13'h0, mem_addr}, {13'h0, exp_addr});
    end
    mem_ack = 1'b1;
    mem_rdata = rd;
    ptr_we = ld;
    ptr_data = ld_val;
    tick();
    mem_ack = 1'b0;
    ptr_we = 1'b0;
    check_eq("req_drop", {31'h0, mem_req}, 32'h0);
    repeat (4) tick();
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst_addr", {13'h0, mem_addr}, 32'h0);
    check_eq("rst_aen", {31'h0, aen}, 32'h0);
    check_eq("rst_address", {30'h0, address}, 32'h0);
    check_eq("rst_data", {16'h0, data_out}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    tick();
    no_fetch(1'b0);  // IDLE ignores slots

    ptr_we = 1'b1;
    ptr_data = 19'h00100;
    tick();
    ptr_we = 1'b0;
    vbl_end = 1'b1;
    tick();
    vbl_end = 1'b0;

    // Control pair
    push_wr(2'b00, 16'h3040);
    fetch(1'b0, 19'h00100, 16'h3040, 0, 0, 1'b0, '0);
    push_wr(2'b01, 16'h3200);
    fetch(1'b1, 19'h00101, 16'h3200, 0, 0, 1'b0, '0);
    vpos = 9'h010;
    no_fetch(1'b0);
    no_fetch(1'b1);

    // Active lines
    vpos = 9'h030;
    fetch(1'b0, 19'h00102, 16'hAAAA, 0, 0, 1'b0, '0);
    push_wr(2'b11, 16'h5555);
    push_wr(2'b10, 16'hAAAA);
    fetch(1'b1, 19'h00103, 16'h5555, 0, 0, 1'b0, '0);
    vpos = 9'h031;
    fetch(1'b0, 19'h00104, 16'h1234, 0, 0, 1'b0, '0);
    push_wr(2'b11, 16'h4321);
    push_wr(2'b10, 16'h1234);
    fetch(1'b1, 19'h00105, 16'h4321, 0, 0, 1'b0, '0);

    // Stop line: zero control pair ends the sprite
    vpos = 9'h032;
    push_wr(2'b00, 16'h0000);
    fetch(1'b0, 19'h00106, 16'h0000, 0, 0, 1'b0, '0);
    push_wr(2'b01, 16'h0000);
    fetch(1'b1, 19'h00107, 16'h0000, 0, 0, 1'b0, '0);
    for (int l = 0; l < 3; l++) begin
      vpos = 9'h033 + 9'(l);
      no_fetch(1'b0);
      no_fetch(1'b1);
    end

    // Restart; equal start/stop displays nothing
    vbl_end = 1'b1;
    tick();
    vbl_end = 1'b0;
    push_wr(2'b00, 16'h5000);
    fetch(1'b0, 19'h00108, 16'h5000, 0, 0, 1'b0, '0);
    push_wr(2'b01, 16'h5000);
    fetch(1'b1, 19'h00109, 16'h5000, 0, 0, 1'b0, '0);
    vpos = 9'h050;
    push_wr(2'b00, 16'h6000);
    fetch(1'b0, 19'h0010A, 16'h6000, 0, 0, 1'b0, '0);
    push_wr(2'b01, 16'h6400);
    fetch(1'b1, 19'h0010B, 16'h6400, 0, 0, 1'b0, '0);

    // Backpressure, ignored slot and pointer load coincident with ack
    vpos = 9'h060;
    fetch(1'b0, 19'h0010C, 16'hCAFE, 5, 1, 1'b1, 19'h7FFFF);
    push_wr(2'b11, 16'hBEEF);
    push_wr(2'b10, 16'hCAFE);
    fetch(1'b1, 19'h7FFFF, 16'hBEEF, 0, 0, 1'b0, '0);
    vpos = 9'h061;
    fetch(1'b0, 19'h00000, 16'h1111, 0, 0, 1'b0, '0);

    // Frame start while DATB fetch is outstanding: data dropped, next slot0 fetches POS
    fetch(1'b1, 19'h00001, 16'h2222, 3, 2, 1'b0, '0);
    push_wr(2'b00, 16'h7000);
    fetch(1'b0, 19'h00002, 16'h7000, 0, 0, 1'b0, '0);

    // Reset in the middle of a handshake
    do_slot(1'b1);
    check_eq("req_before_rst", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    tick();
    check_eq("req_after_rst", {31'h0, mem_req}, 32'h0);
    check_eq("busy_after_rst", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (3) tick();

    check_eq("sb_empty", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
